// File: rtl/rst_sequencer_pkg.sv
// rst_seq_pkg: shared state encoding, output widths and counter sizing for rst_sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rst_seq_pkg;

  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  // Width of the one counter shared by HOLD, STABLE and RELEASE.
  function automatic int cnt_width(input int hold_c, input int stable_c, input int stagger_c);
    int m;
    m = hold_c;
    if (stable_c > m) m = stable_c;
    if (stagger_c > m) m = stagger_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: lock inputs, domain enables/resets and debug status of the reset sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; slave is the sequencer, master is the board-level logic around it.
interface rst_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int NUM_LOCKS   = 2
);
  logic [NUM_LOCKS-1:0]   LOCK_IN;
  logic [NUM_DOMAINS-1:0] DOMAIN_EN;
  logic                   SW_RESET_REQ;
  logic [NUM_DOMAINS-1:0] DOMAIN_RESET;
  logic                   ALL_READY;
  logic                   PLL_LOCKED;
  logic [STATE_W-1:0]     STATE;
  logic [LOSS_W-1:0]      LOSS_COUNT;

  modport master (
    output LOCK_IN, DOMAIN_EN, SW_RESET_REQ,
    input  DOMAIN_RESET, ALL_READY, PLL_LOCKED, STATE, LOSS_COUNT
  );

  modport slave (
    input  LOCK_IN, DOMAIN_EN, SW_RESET_REQ,
    output DOMAIN_RESET, ALL_READY, PLL_LOCKED, STATE, LOSS_COUNT
  );
endinterface

// File: rtl/rst_sequencer_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser for an asynchronous level input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: qualifies lock inputs, then releases domain resets lowest-first, staggered.
// Latency: lock drop -> all DOMAIN_RESET high after 3 SYS_CLK edges; every output registered.
// Backpressure: none; SW_RESET_REQ is a one-cycle pulse. Build macro RST_SEQ_LOSS_CNT_EN enables LOSS_COUNT.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS        = 4,
  parameter int NUM_LOCKS          = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 64,
  parameter int HOLD_CYCLES        = 16
) (
  input  logic           SYS_CLK,
  input  logic           RESET,
  rst_sequencer_if.slave bus
);
  localparam int CNT_W = cnt_width(HOLD_CYCLES, LOCK_STABLE_CYCLES, STAGGER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_FIRST = (STAGGER_CYCLES > 1) ? CNT_W'(1) : '0;

  logic [NUM_LOCKS-1:0]   lock_s;
  logic                   all_locked;
  state_e                 state;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   all_ready;
  logic                   pll_locked;
  logic [NUM_DOMAINS-1:0] remaining;
  logic [NUM_DOMAINS-1:0] low_bit;
  logic                   lock_lost;
  logic                   seq_abort;

  for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_lock_sync
    sync_2ff u_sync (
      .clk (SYS_CLK),
      .rst (RESET),
      .d   (bus.LOCK_IN[g]),
      .q   (lock_s[g])
    );
  end

  assign all_locked = &lock_s;

  // Enabled domains still held; the lowest of them is released next.
  assign remaining = bus.DOMAIN_EN & dom_rst;
  assign low_bit   = remaining & (~remaining + NUM_DOMAINS'(1));

  // A lock drop only counts as a loss once release has started.
  assign lock_lost = !all_locked && (state == RELEASE || state == RUN);
  assign seq_abort = lock_lost || (bus.SW_RESET_REQ && state != HOLD);

  // Sequencer FSM; cnt is restarted on every state change. In STABLE it holds the
  // number of already-qualified cycles, including the WAIT_LOCK cycle that saw the locks.
  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      state      <= HOLD;
      cnt        <= '0;
      dom_rst    <= '1;
      all_ready  <= 1'b0;
      pll_locked <= 1'b0;
    end else begin
      pll_locked <= all_locked;
      if (seq_abort) begin
        state     <= HOLD;
        cnt       <= '0;
        dom_rst   <= '1;
        all_ready <= 1'b0;
      end else begin
        case (state)
          HOLD: begin
            if (bus.SW_RESET_REQ) begin
              cnt <= '0;
            end else if (cnt == HOLD_LAST) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          WAIT_LOCK: begin
            if (all_locked) begin
              state <= STABLE;
              cnt   <= CNT_ONE;
            end
          end
          STABLE: begin
            if (!all_locked) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt >= STABLE_LAST) begin
              state <= RELEASE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          RELEASE: begin
            if (remaining == '0) begin
              state     <= RUN;
              cnt       <= '0;
              all_ready <= 1'b1;
            end else if (cnt == '0) begin
              dom_rst <= dom_rst & ~low_bit;
              cnt     <= STAGGER_FIRST;
            end else if (cnt == STAGGER_LAST) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          RUN: begin
            all_ready <= 1'b1;
          end
          default: begin
            state   <= HOLD;
            cnt     <= '0;
            dom_rst <= '1;
          end
        endcase
      end
    end
  end

  assign bus.DOMAIN_RESET = dom_rst;
  assign bus.ALL_READY    = all_ready;
  assign bus.PLL_LOCKED   = pll_locked;
  assign bus.STATE        = state;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_cnt;

  // Saturating lock-loss counter, cleared only by RESET.
  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      loss_cnt <= '0;
    end else if (lock_lost && loss_cnt != '1) begin
      loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end

  assign bus.LOSS_COUNT = loss_cnt;
`else
  assign bus.LOSS_COUNT = '0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: checks power-up, glitch, lock loss, masking, SW request, saturation, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

`ifdef RST_SEQ_LOSS_CNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic sys_clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   lc_model;

  rst_sequencer_if #(.NUM_DOMAINS(3), .NUM_LOCKS(2)) bus ();

  rst_sequencer #(
    .NUM_DOMAINS        (3),
    .NUM_LOCKS          (2),
    .LOCK_STABLE_CYCLES (16),
    .STAGGER_CYCLES     (4),
    .HOLD_CYCLES        (8)
  ) dut (
    .SYS_CLK (sys_clk),
    .RESET   (reset),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string      name;
    int         adv;
    logic       rst;
    logic [1:0] lock;
    logic [2:0] en;
    logic       sw;
    logic [2:0] dr;
    logic       ar;
    logic       pl;
    logic [2:0] st;
    logic [7:0] lc;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] dr;
    logic       ar;
    logic       pl;
    logic [2:0] st;
    logic [7:0] lc;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input string name, input int adv, input logic rst,
                              input logic [1:0] lock, input logic [2:0] en, input logic sw,
                              input logic [2:0] dr, input logic ar, input logic pl,
                              input logic [2:0] st, input int lc);
    vec_t v;
    v.name = name; v.adv = adv; v.rst = rst; v.lock = lock; v.en = en; v.sw = sw;
    v.dr = dr; v.ar = ar; v.pl = pl; v.st = st;
    v.lc = LC_EN ? 8'(lc) : 8'd0;
    return v;
  endfunction

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.DOMAIN_RESET !== e.dr || bus.ALL_READY !== e.ar || bus.PLL_LOCKED !== e.pl ||
        bus.STATE !== e.st || bus.LOSS_COUNT !== e.lc) begin
      n_err++;
      $display("FAIL %s: got dr=%b ar=%b pl=%b st=%0d lc=%0d, want dr=%b ar=%b pl=%b st=%0d lc=%0d",
               e.name, bus.DOMAIN_RESET, bus.ALL_READY, bus.PLL_LOCKED, bus.STATE, bus.LOSS_COUNT,
               e.dr, e.ar, e.pl, e.st, e.lc);
    end
  endtask

  // Drive one vector (SW pulse lasts one edge), run adv edges, compare at the negedge.
  task automatic apply(input vec_t v);
    exp_t e;
    reset            = v.rst;
    bus.LOCK_IN      = v.lock;
    bus.DOMAIN_EN    = v.en;
    bus.SW_RESET_REQ = v.sw;
    e.name = v.name; e.dr = v.dr; e.ar = v.ar; e.pl = v.pl; e.st = v.st; e.lc = v.lc;
    exp_q.push_back(e);
    for (int k = 0; k < v.adv; k++) begin
      @(posedge sys_clk);
      #1;
      bus.SW_RESET_REQ = 1'b0;
    end
    @(negedge sys_clk);
    check_out();
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int budget);
    int k;
    k = 0;
    while (bus.STATE !== st && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    n_cmp++;
    if (bus.STATE !== st) begin
      n_err++;
      $display("FAIL %s: state=%0d, want %0d within %0d cycles", name, bus.STATE, st, budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want summary first");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.LOCK_IN = 2'b11;
    bus.DOMAIN_EN = 3'b111;
    bus.SW_RESET_REQ = 1'b0;

    //                  name            adv rst lock   en      sw  dr      ar  pl  st  lc
    // Power-up with locks high.
    tbl.push_back(mk("por_reset",      3, 1, 2'b11, 3'b111, 0, 3'b111, 0, 0, 0, 0));
    tbl.push_back(mk("por_hold",       7, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 0, 0));
    tbl.push_back(mk("por_wait",       1, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 1, 0));
    tbl.push_back(mk("por_stable",     1, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 2, 0));
    tbl.push_back(mk("por_stable_end",14, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 2, 0));
    tbl.push_back(mk("por_release",    1, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 3, 0));
    tbl.push_back(mk("por_dom0",       1, 0, 2'b11, 3'b111, 0, 3'b110, 0, 1, 3, 0));
    tbl.push_back(mk("por_dom1_pre",   3, 0, 2'b11, 3'b111, 0, 3'b110, 0, 1, 3, 0));
    tbl.push_back(mk("por_dom1",       1, 0, 2'b11, 3'b111, 0, 3'b100, 0, 1, 3, 0));
    tbl.push_back(mk("por_dom2_pre",   3, 0, 2'b11, 3'b111, 0, 3'b100, 0, 1, 3, 0));
    tbl.push_back(mk("por_dom2",       1, 0, 2'b11, 3'b111, 0, 3'b000, 0, 1, 3, 0));
    tbl.push_back(mk("por_run",        1, 0, 2'b11, 3'b111, 0, 3'b000, 1, 1, 4, 0));
    // Reset mid-RUN, then a one-cycle glitch on LOCK_IN[1] at STABLE+10.
    tbl.push_back(mk("gl_reset",       1, 1, 2'b11, 3'b111, 0, 3'b111, 0, 0, 0, 0));
    tbl.push_back(mk("gl_wait",        8, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 1, 0));
    tbl.push_back(mk("gl_stable",      1, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 2, 0));
    tbl.push_back(mk("gl_stable10",   10, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 2, 0));
    tbl.push_back(mk("gl_drop",        1, 0, 2'b01, 3'b111, 0, 3'b111, 0, 1, 2, 0));
    tbl.push_back(mk("gl_restore",     1, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 2, 0));
    tbl.push_back(mk("gl_back_wait",   1, 0, 2'b11, 3'b111, 0, 3'b111, 0, 0, 1, 0));
    tbl.push_back(mk("gl_restable",    1, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 2, 0));
    tbl.push_back(mk("gl_requal_end", 14, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 2, 0));
    tbl.push_back(mk("gl_release",     1, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 3, 0));
    tbl.push_back(mk("gl_dom0",        1, 0, 2'b11, 3'b111, 0, 3'b110, 0, 1, 3, 0));
    tbl.push_back(mk("gl_run",         9, 0, 2'b11, 3'b111, 0, 3'b000, 1, 1, 4, 0));
    // Lock loss in RUN: outputs react on the third edge after the input drop.
    tbl.push_back(mk("loss_sync",      2, 0, 2'b10, 3'b111, 0, 3'b000, 1, 1, 4, 0));
    tbl.push_back(mk("loss_hold",      1, 0, 2'b10, 3'b111, 0, 3'b111, 0, 0, 0, 1));
    // Masked domain 1.
    tbl.push_back(mk("mask_wait",      8, 0, 2'b11, 3'b101, 0, 3'b111, 0, 1, 1, 1));
    tbl.push_back(mk("mask_stable",    1, 0, 2'b11, 3'b101, 0, 3'b111, 0, 1, 2, 1));
    tbl.push_back(mk("mask_release",  15, 0, 2'b11, 3'b101, 0, 3'b111, 0, 1, 3, 1));
    tbl.push_back(mk("mask_dom0",      1, 0, 2'b11, 3'b101, 0, 3'b110, 0, 1, 3, 1));
    tbl.push_back(mk("mask_dom2_pre",  3, 0, 2'b11, 3'b101, 0, 3'b110, 0, 1, 3, 1));
    tbl.push_back(mk("mask_dom2",      1, 0, 2'b11, 3'b101, 0, 3'b010, 0, 1, 3, 1));
    tbl.push_back(mk("mask_run",       1, 0, 2'b11, 3'b101, 0, 3'b010, 1, 1, 4, 1));
    tbl.push_back(mk("mask_held",     20, 0, 2'b11, 3'b101, 0, 3'b010, 1, 1, 4, 1));
    // SW request in RUN, then again mid-RELEASE after domain 0 is out.
    tbl.push_back(mk("sw_run",         1, 0, 2'b11, 3'b111, 1, 3'b111, 0, 1, 0, 1));
    tbl.push_back(mk("sw_rel_dom0",   25, 0, 2'b11, 3'b111, 0, 3'b110, 0, 1, 3, 1));
    tbl.push_back(mk("sw_rel_mid",     1, 0, 2'b11, 3'b111, 0, 3'b110, 0, 1, 3, 1));
    tbl.push_back(mk("sw_rel_req",     1, 0, 2'b11, 3'b111, 1, 3'b111, 0, 1, 0, 1));
    tbl.push_back(mk("sw_re_wait",     8, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 1, 1));
    tbl.push_back(mk("sw_re_release", 16, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 3, 1));
    tbl.push_back(mk("sw_re_dom0",     1, 0, 2'b11, 3'b111, 0, 3'b110, 0, 1, 3, 1));
    tbl.push_back(mk("sw_re_run",      9, 0, 2'b11, 3'b111, 0, 3'b000, 1, 1, 4, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Saturation: 260 more lock losses, first from RUN then from RELEASE.
    lc_model = 1;
    for (int i = 0; i < 260; i++) begin
      bus.LOCK_IN = 2'b10;
      wait_state("sat_to_hold", 3'd0, 6);
      lc_model = (lc_model < 255) ? lc_model + 1 : 255;
      n_cmp++;
      if (bus.LOSS_COUNT !== (LC_EN ? 8'(lc_model) : 8'd0)) begin
        n_err++;
        $display("FAIL sat_count[%0d]: got %0d, want %0d", i, bus.LOSS_COUNT,
                 LC_EN ? lc_model : 0);
      end
      bus.LOCK_IN = 2'b11;
      wait_state("sat_to_release", 3'd3, 40);
    end
    wait_state("sat_to_run", 3'd4, 20);
    n_cmp++;
    if (bus.LOSS_COUNT !== (LC_EN ? 8'd255 : 8'd0) || bus.ALL_READY !== 1'b1) begin
      n_err++;
      $display("FAIL sat_final: got lc=%0d ar=%b, want lc=%0d ar=1", bus.LOSS_COUNT,
               bus.ALL_READY, LC_EN ? 255 : 0);
    end

    // RESET mid-RUN: reset values on the next edge, then a normal HOLD restart.
    apply(mk("rst_mid_run",   1, 1, 2'b11, 3'b111, 0, 3'b111, 0, 0, 0, 0));
    apply(mk("rst_post_hold", 3, 0, 2'b11, 3'b111, 0, 3'b111, 0, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
